// File: rtl/c8b_32b_asm_pkg.sv
// rtl/c8b_32b_asm_pkg.sv - shared PHY byte-lane constants and lane-index type
package c8b_32b_asm_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    // Shared with the 32b->8b serializer so both sides agree on lane numbering.
    typedef logic [$clog2(LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/c8b_32b_asm_outreg.sv
// rtl/c8b_32b_asm_outreg.sv - single-entry valid/ready output register with sticky overflow
module c8b_32b_asm_outreg
    import c8b_32b_asm_pkg::*;
#(
    parameter int W = BYTE_W * LANES
) (
    input  logic         clock4,
    input  logic         reset,
    input  logic         word_valid,
    input  logic [W-1:0] word_data,
    input  logic         ready_in,
    output logic [W-1:0] data_out,
    output logic         valid_out,
    output logic         overflow
);

    always_ff @(posedge clock4) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (word_valid) begin
            if (!valid_out || ready_in) begin
                data_out  <= word_data;
                valid_out <= 1'b1;
            end else begin
                // Source cannot be stalled: the new word is lost, the held one survives.
                overflow <= 1'b1;
            end
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/c8b_32b_asm.sv
// rtl/c8b_32b_asm.sv - reassembles the serializer's byte stream into 32-bit words
module c8b_32b_asm #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                  clock4,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  valid_in,
    input  logic                  align_in,
    output logic [DATA_W*LANES-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  overflow,
    output logic [1:0]            lane_idx
);
    import c8b_32b_asm_pkg::*;

    localparam int WORD_W = DATA_W * LANES;

    lane_idx_t         lane_q;
    lane_idx_t         lane_next;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_next;
    logic              complete;

    assign complete = valid_in && !align_in && (lane_q == lane_idx_t'(LANES - 1));

    always_comb begin
        asm_next  = asm_q;
        lane_next = lane_q;
        if (align_in) begin
            // Realignment throws away any partial word, including its byte lanes.
            asm_next = '0;
            if (valid_in) begin
                asm_next[DATA_W-1:0] = data_in;
                lane_next            = lane_idx_t'(1);
            end else begin
                lane_next = '0;
            end
        end else if (valid_in) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_q == lane_idx_t'(i)) begin
                    asm_next[i*DATA_W +: DATA_W] = data_in;
                end
            end
            lane_next = lane_q + lane_idx_t'(1);
        end
    end

    always_ff @(posedge clock4) begin
        if (reset) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_next;
            asm_q  <= asm_next;
        end
    end

    assign lane_idx = lane_q;

    // The completed word already includes the byte landing in the top lane this cycle.
    c8b_32b_asm_outreg #(
        .W (WORD_W)
    ) u_outreg (
        .clock4     (clock4),
        .reset      (reset),
        .word_valid (complete),
        .word_data  (asm_next),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .overflow   (overflow)
    );

endmodule
